gpac_adc_fifo_arbiter: RTL and testbench



---
 rtl/gpac_adc_fifo_arbiter_if.sv | 44 ++++
 rtl/gpac_adc_fifo_arbiter.sv | 124 ++++++++++++
 tb/tb_gpac_adc_fifo_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpac_adc_fifo_arbiter_if.sv
// Bus bundle between the per-channel ADC receiver FIFOs, the arbiter and the
// single downstream FIFO consumer.
//
// Handshake: every stream here is first-word-fall-through. A word is valid
// whenever its EMPTY flag is low; the reader takes it by raising READ in that
// same cycle, and the word counts as transferred only when READ && !EMPTY at
// the clock edge. READ while EMPTY is high is legal and has no effect.
`timescale 1ns/1ps
interface gpac_adc_fifo_arbiter_if #(
    parameter int N_CH = 4
);
    localparam int IW = $clog2(N_CH);

    // Channel side (one lane per ADC receiver)
    logic [N_CH-1:0]    CH_ENABLE;
    logic [N_CH-1:0]    CH_FIFO_EMPTY;
    logic [32*N_CH-1:0] CH_FIFO_DATA;
    logic [N_CH-1:0]    CH_FIFO_READ;

    // Merged downstream stream
    logic               FIFO_READ;
    logic               FIFO_EMPTY;
    logic [31:0]        FIFO_DATA;

    // Status
    logic [N_CH-1:0]    GRANT;
    logic               BUSY;

    // Debug view of the arbiter bookkeeping
    logic [IW-1:0]      dbg_ptr;
    logic [7:0]         dbg_burst_cnt;

    modport slave (
        input  CH_ENABLE, CH_FIFO_EMPTY, CH_FIFO_DATA, FIFO_READ,
        output CH_FIFO_READ, FIFO_EMPTY, FIFO_DATA, GRANT, BUSY,
        output dbg_ptr, dbg_burst_cnt
    );

    modport master (
        output CH_ENABLE, CH_FIFO_EMPTY, CH_FIFO_DATA, FIFO_READ,
        input  CH_FIFO_READ, FIFO_EMPTY, FIFO_DATA, GRANT, BUSY,
        input  dbg_ptr, dbg_burst_cnt
    );
endinterface

// File: rtl/gpac_adc_fifo_arbiter.sv
// Round-robin read arbiter merging N_CH FWFT channel FIFOs into one FWFT
// stream. One channel is granted at a time for at most MAX_BURST words; the
// data path is purely combinational, so nothing is buffered inside.
// The interface instance must be built with the same N_CH as this module.
`timescale 1ns/1ps
module gpac_adc_fifo_arbiter #(
    parameter int N_CH      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST,
    gpac_adc_fifo_arbiter_if.slave bus
);
    localparam int         IW        = $clog2(N_CH);
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   grant_idx, grant_idx_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [7:0]      burst_cnt, burst_cnt_n;

    logic [N_CH-1:0] cand;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic            cur_empty;
    logic            transfer;

    // (base + off) mod N_CH for base < N_CH and 0 <= off < N_CH
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) s = s - N_CH;
        return IW'(s);
    endfunction

    // Pick the first ready channel scanning upward from ptr; scanning the
    // offsets downward lets the smallest offset win without a break
    always_comb begin
        cand       = bus.CH_ENABLE & ~bus.CH_FIFO_EMPTY;
        pick_found = 1'b0;
        pick_idx   = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (cand[wrap_add(ptr, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(ptr, k);
            end
        end
    end

    // Next-state logic plus the combinational grant-side data path
    always_comb begin
        state_n          = state;
        grant_idx_n      = grant_idx;
        ptr_n            = ptr;
        burst_cnt_n      = burst_cnt;
        cur_empty        = 1'b1;
        transfer         = 1'b0;
        bus.FIFO_EMPTY   = 1'b1;
        bus.FIFO_DATA    = '0;
        bus.CH_FIFO_READ = '0;
        bus.GRANT        = '0;
        bus.BUSY         = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_n     = S_GRANT;
                    grant_idx_n = pick_idx;
                    burst_cnt_n = '0;
                end
            end
            S_GRANT: begin
                // A disabled channel looks empty immediately, which also
                // forces the release below at the coming edge
                cur_empty = bus.CH_FIFO_EMPTY[grant_idx] | ~bus.CH_ENABLE[grant_idx];
                transfer  = bus.FIFO_READ & ~cur_empty;

                bus.FIFO_EMPTY              = cur_empty;
                bus.FIFO_DATA               = bus.CH_FIFO_DATA[{grant_idx, 5'b0} +: 32];
                bus.CH_FIFO_READ[grant_idx] = transfer;
                bus.GRANT[grant_idx]        = 1'b1;
                bus.BUSY                    = 1'b1;

                if (transfer) begin
                    burst_cnt_n = burst_cnt + 8'd1;
                end
                // Release on a full burst or when the channel has nothing
                // to offer this cycle; priority moves past the granted one
                if ((transfer && (burst_cnt == LAST_BEAT)) || cur_empty) begin
                    state_n     = S_IDLE;
                    ptr_n       = wrap_add(grant_idx, 1);
                    burst_cnt_n = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Bookkeeping registers; async reset drops the grant and every strobe
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state     <= S_IDLE;
            grant_idx <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            grant_idx <= grant_idx_n;
            ptr       <= ptr_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    assign bus.dbg_ptr       = ptr;
    assign bus.dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_gpac_adc_fifo_arbiter.sv
// Bench for gpac_adc_fifo_arbiter: emulated channel FIFOs (queues), a
// transaction-level model of the round-robin/burst rules checked every
// cycle, and directed scenarios with hand-computed expected streams.
`timescale 1ns/1ps
module tb_gpac_adc_fifo_arbiter;
    localparam int N  = 4;
    localparam int MB = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    gpac_adc_fifo_arbiter_if #(.N_CH(N)) bus ();
    gpac_adc_fifo_arbiter_if #(.N_CH(N)) bus1 ();

    gpac_adc_fifo_arbiter #(.N_CH(N), .MAX_BURST(MB)) dut (
        .BUS_CLK (clk),
        .BUS_RST (rst),
        .bus     (bus.slave)
    );

    gpac_adc_fifo_arbiter #(.N_CH(N), .MAX_BURST(1)) dut1 (
        .BUS_CLK (clk),
        .BUS_RST (rst),
        .bus     (bus1.slave)
    );

    logic [N-1:0] ch_en, ch_en1;
    logic         fifo_read, fifo_read1;
    assign bus.CH_ENABLE  = ch_en;
    assign bus.FIFO_READ  = fifo_read;
    assign bus1.CH_ENABLE = ch_en1;
    assign bus1.FIFO_READ = fifo_read1;

    // ---------------- bench state ----------------
    logic [31:0] ch_q[N][$];     // channel FIFO contents, main DUT
    logic [31:0] ch_q1[N][$];    // channel FIFO contents, MAX_BURST=1 DUT
    logic [31:0] rx_q[$];        // words delivered downstream
    logic [31:0] rx1_q[$];
    logic [31:0] exp_q[$];       // expected downstream stream
    logic        busy1_q[$];
    int          grant_log[$];
    logic        rec1 = 1'b0;

    int m_owner = -1;            // model: granted channel, -1 when none
    int m_next  = 0;             // model: channel with first priority
    int m_count = 0;             // model: words moved in current grant

    int n_checks = 0;
    int n_errs   = 0;

    function automatic logic [31:0] w(input int c, input int s);
        return 32'hAD00_0000 | (32'(c) << 8) | 32'(s);
    endfunction

    function automatic logic [31:0] filler(input int c);
        return 32'hDEAD_0000 | 32'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), rx_q[i], exp_q[i]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- model + per-cycle compare ----------------
    task automatic model_step();
        logic         e_empty, e_busy, avail, found;
        logic [31:0]  e_data;
        logic [N-1:0] e_grant, e_rd;
        avail   = 1'b0;
        e_empty = 1'b1;
        e_busy  = 1'b0;
        e_data  = '0;
        e_grant = '0;
        e_rd    = '0;
        if (!rst && m_owner >= 0) begin
            avail   = ch_en[m_owner] && (ch_q[m_owner].size() > 0);
            e_empty = !avail;
            e_busy  = 1'b1;
            e_data  = (ch_q[m_owner].size() > 0) ? ch_q[m_owner][0] : filler(m_owner);
            e_grant[m_owner] = 1'b1;
            if (avail && fifo_read) e_rd = e_grant;
        end
        check("FIFO_EMPTY",   32'(bus.FIFO_EMPTY),   32'(e_empty));
        check("FIFO_DATA",    bus.FIFO_DATA,         e_data);
        check("GRANT",        32'(bus.GRANT),        32'(e_grant));
        check("BUSY",         32'(bus.BUSY),         32'(e_busy));
        check("CH_FIFO_READ", 32'(bus.CH_FIFO_READ), 32'(e_rd));
        check("ptr",          32'(bus.dbg_ptr),      rst ? 32'd0 : 32'(m_next));
        if (!rst && m_owner >= 0) begin
            check("burst_cnt", 32'(bus.dbg_burst_cnt), 32'(m_count));
        end

        // downstream consumer
        if (fifo_read && !bus.FIFO_EMPTY) rx_q.push_back(bus.FIFO_DATA);

        // advance model to the state after the coming edge
        if (rst) begin
            m_owner = -1;
            m_next  = 0;
            m_count = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_next + k) % N;
                if (!found && ch_en[c] && ch_q[c].size() > 0) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_count = 0;
                    grant_log.push_back(c);
                end
            end
        end else if (avail && fifo_read) begin
            m_count++;
            if (m_count == MB) begin
                m_next  = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else if (!avail) begin
            m_next  = (m_owner + 1) % N;
            m_owner = -1;
        end

        // channel FIFOs honour the strobes the DUT actually issued
        for (int i = 0; i < N; i++) begin
            if (bus.CH_FIFO_READ[i] && ch_q[i].size() > 0) void'(ch_q[i].pop_front());
        end
    endtask

    // Drive channel FIFO heads after the falling edge, then compare
    always begin
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            bus.CH_FIFO_EMPTY[i]         = (ch_q[i].size() == 0);
            bus.CH_FIFO_DATA[32*i +: 32] = (ch_q[i].size() != 0) ? ch_q[i][0] : filler(i);
        end
        #1;
        model_step();
    end

    // Channel FIFO emulation and recording for the MAX_BURST=1 instance
    always begin
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            bus1.CH_FIFO_EMPTY[i]         = (ch_q1[i].size() == 0);
            bus1.CH_FIFO_DATA[32*i +: 32] = (ch_q1[i].size() != 0) ? ch_q1[i][0] : filler(i);
        end
        #1;
        if (rec1) busy1_q.push_back(bus1.BUSY);
        if (fifo_read1 && !bus1.FIFO_EMPTY) rx1_q.push_back(bus1.FIFO_DATA);
        for (int i = 0; i < N; i++) begin
            if (bus1.CH_FIFO_READ[i] && ch_q1[i].size() > 0) void'(ch_q1[i].pop_front());
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst        = 1'b1;
        ch_en      = '0;
        fifo_read  = 1'b0;
        ch_en1     = '0;
        fifo_read1 = 1'b0;

        // reset values
        cyc(2);
        #3;
        check("rst_GRANT",        32'(bus.GRANT),         32'h0);
        check("rst_BUSY",         32'(bus.BUSY),          32'h0);
        check("rst_FIFO_EMPTY",   32'(bus.FIFO_EMPTY),    32'h1);
        check("rst_FIFO_DATA",    bus.FIFO_DATA,          32'h0);
        check("rst_CH_FIFO_READ", 32'(bus.CH_FIFO_READ),  32'h0);
        check("rst_burst_cnt",    32'(bus.dbg_burst_cnt), 32'h0);

        cyc(1);
        rst       = 1'b0;
        ch_en     = '1;
        fifo_read = 1'b1;

        // single channel: ch2 holds A0..A4
        cyc(1);
        rx_q.delete();
        grant_log.delete();
        for (int s = 0; s < 5; s++) ch_q[2].push_back(32'hA0 + 32'(s));
        cyc(1);
        #3;
        check("single_grant", 32'(bus.GRANT), 32'h4);
        cyc(8);
        #3;
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        check_stream("single");
        check("single_ptr",  32'(bus.dbg_ptr), 32'd3);
        check("single_busy", 32'(bus.BUSY),    32'd0);

        // reset after 7 words of a ch1 burst; ch0 fills during reset
        cyc(1);
        rx_q.delete();
        grant_log.delete();
        for (int s = 0; s < 12; s++) ch_q[1].push_back(w(1, s));
        cyc(8);
        rst = 1'b1;
        for (int s = 0; s < 3; s++) ch_q[0].push_back(w(0, s));
        #3;
        check("rstmid_words", 32'(rx_q.size()),      32'd7);
        check("rstmid_GRANT", 32'(bus.GRANT),        32'h0);
        check("rstmid_read",  32'(bus.CH_FIFO_READ), 32'h0);
        check("rstmid_empty", 32'(bus.FIFO_EMPTY),   32'h1);
        check("rstmid_ptr",   32'(bus.dbg_ptr),      32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(14);
        #3;
        check("rstmid_ngrants", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check("rstmid_g0", 32'(grant_log[0]), 32'd1);
            check("rstmid_g1", 32'(grant_log[1]), 32'd0);
            check("rstmid_g2", 32'(grant_log[2]), 32'd1);
        end
        exp_q.delete();
        for (int s = 0; s < 7; s++)  exp_q.push_back(w(1, s));
        for (int s = 0; s < 3; s++)  exp_q.push_back(w(0, s));
        for (int s = 7; s < 12; s++) exp_q.push_back(w(1, s));
        check_stream("rstmid");

        // fairness: fresh reset so the sweep starts at ch0, 40 words each
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        rx_q.delete();
        grant_log.delete();
        for (int c = 0; c < N; c++)
            for (int s = 0; s < 40; s++) ch_q[c].push_back(w(c, s));
        cyc(180);
        #3;
        check("fair_ngrants", 32'(grant_log.size()), 32'd12);
        for (int k = 0; k < grant_log.size() && k < 12; k++) begin
            check($sformatf("fair_g%0d", k), 32'(grant_log[k]), 32'(k % N));
        end
        exp_q.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < N; c++)
                for (int s = r * 16; s < r * 16 + 16 && s < 40; s++) exp_q.push_back(w(c, s));
        check_stream("fair");
        check("fair_w15", (rx_q.size() > 16) ? rx_q[15] : 32'h0, 32'hAD00_000F);
        check("fair_w16", (rx_q.size() > 16) ? rx_q[16] : 32'h0, 32'hAD00_0100);

        // disable mid-burst: ch1 granted, 2 words read, then disabled
        cyc(1);
        rx_q.delete();
        grant_log.delete();
        for (int s = 0; s < 10; s++) ch_q[1].push_back(w(1, s));
        for (int s = 0; s < 4; s++)  ch_q[2].push_back(w(2, s));
        cyc(3);
        ch_en = 4'b1101;
        #3;
        check("dis_empty", 32'(bus.FIFO_EMPTY),   32'h1);
        check("dis_read",  32'(bus.CH_FIFO_READ), 32'h0);
        check("dis_grant", 32'(bus.GRANT),        32'h2);
        cyc(2);
        #3;
        check("dis_next_grant", 32'(bus.GRANT), 32'h4);
        cyc(5);
        #3;
        check("dis_ch1_left", 32'(ch_q[1].size()), 32'd8);
        exp_q = '{w(1, 0), w(1, 1), w(2, 0), w(2, 1), w(2, 2), w(2, 3)};
        check_stream("dis");
        cyc(1);
        ch_en = '1;
        cyc(12);

        // downstream stall on ch3 for 20 cycles
        fifo_read = 1'b0;
        rx_q.delete();
        for (int s = 0; s < 3; s++) ch_q[3].push_back(w(3, s));
        cyc(20);
        #3;
        check("stall_grant", 32'(bus.GRANT),         32'h8);
        check("stall_cnt",   32'(bus.dbg_burst_cnt), 32'd0);
        check("stall_data",  bus.FIFO_DATA,          32'hAD00_0300);
        check("stall_empty", 32'(bus.FIFO_EMPTY),    32'h0);
        check("stall_rx",    32'(rx_q.size()),       32'd0);
        cyc(1);
        fifo_read = 1'b1;
        cyc(6);
        #3;
        exp_q = '{w(3, 0), w(3, 1), w(3, 2)};
        check_stream("stall");
        check("stall_ptr", 32'(bus.dbg_ptr), 32'd0);

        // MAX_BURST=1 instance: ch0 and ch1 with 3 words each
        cyc(1);
        for (int s = 0; s < 3; s++) begin
            ch_q1[0].push_back(w(0, s));
            ch_q1[1].push_back(w(1, s));
        end
        ch_en1     = '1;
        fifo_read1 = 1'b1;
        rec1       = 1'b1;
        cyc(12);
        #3;
        rec1 = 1'b0;
        rx_q  = rx1_q;
        exp_q = '{w(0, 0), w(1, 0), w(0, 1), w(1, 1), w(0, 2), w(1, 2)};
        check_stream("mb1");
        check("mb1_trace_len", 32'(busy1_q.size()), 32'd13);
        for (int k = 0; k < busy1_q.size() && k < 13; k++) begin
            check($sformatf("mb1_busy%0d", k), 32'(busy1_q[k]), 32'(k % 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
